lcd_timing_pattern_gen: RTL and testbench
=========================================

Name: lcd_timing_pattern_gen

Overview:
Parametrised LCD timing generator with built-in test-pattern source. It is the successor to the fixed 480x272 panel test block. It drives a parallel RGB panel (hsync/vsync/de/rgb) directly from the pixel clock domain. Panel geometry, sync polarity, colour depth and debounce time are parameters. Mode changes take effect only at frame boundaries, which prevents tearing. An external register load path for the mode sits alongside the push-button.

Parameters:
H_ACTIVE, 480, visible pixels per line
H_SYNC, 41, hsync pulse width (clocks)
H_BP, 2, horizontal back porch
H_FP, 2, horizontal front porch
V_ACTIVE, 272, visible lines per frame
V_SYNC, 10, vsync pulse width (lines)
V_BP, 2, vertical back porch
V_FP, 2, vertical front porch
SYNC_ACTIVE_HIGH, 0, sync polarity; 0 = sync pulses low
COLOR_W, 8, bits per colour channel (4..10)
DEBOUNCE_CYCLES, 50000, stable-press clocks before a key event
KEY_ACTIVE_LOW, 1, key polarity

Ports:
lcd_clk  in  1  pixel clock; sole clock
rst_n  in  1  asynchronous active-low reset
key  in  1  mode-advance push-button, asynchronous to lcd_clk
mode_load  in  1  one-cycle strobe; queues mode_in as next mode
mode_in  in  4  mode value for mode_load
mode_out  out  4  mode currently displayed
lcd_hsync  out  1  horizontal sync
lcd_vsync  out  1  vertical sync
lcd_de  out  1  data enable
lcd_r  out  COLOR_W  red
lcd_g  out  COLOR_W  green
lcd_b  out  COLOR_W  blue
frame_start  out  1  one-cycle pulse, first clock of vsync pulse
pix_x  out  clog2(H_ACTIVE)  active column, valid with lcd_de
pix_y  out  clog2(V_ACTIVE)  active row, valid with lcd_de

Behaviour:
- Clocking and reset: one clock, lcd_clk. Reset is asynchronous, active-low (rst_n).
- Derived totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps. It runs 0..V_TOTAL-1 and wraps to 0.
- Sync and enable windows:
  - sync asserted while cnt < SYNC.
  - active while SYNC+BP <= cnt < SYNC+BP+ACTIVE.
  - lcd_de = h_active AND v_active.
- Output registration and latency:
  - All panel outputs, frame_start, pix_x and pix_y are registered together.
  - Latency is exactly 1 clock from counter state to pins; all outputs stay mutually aligned.
  - rgb is forced to 0 whenever lcd_de = 0.
- Reset values:
  - h_cnt = v_cnt = 0.
  - Syncs at inactive level.
  - lcd_de = 0, rgb = 0, frame_start = 0, pix_x = pix_y = 0.
  - mode_out = 0, pending mode = 0, debounce state idle.
  - Reset mid-frame restarts timing at h_cnt = v_cnt = 0 on the first clock after release.
- frame_start fires when h_cnt = 0 and v_cnt = 0 (output one clock later, with sync).
- Key path:
  - 2-FF synchroniser, then polarity normalised.
  - The counter increments while the key is pressed and clears when released.
  - Exactly one advance event fires when the counter reaches DEBOUNCE_CYCLES; holding the key produces no repeat.
- Pending mode:
  - Updated by key advance (pending+1, wrapping 13->0; 14 when MOVING_BAR_EN: 14->0) or by mode_load (mode_in).
  - mode_load wins if both occur in the same cycle.
- mode_out takes the pending value only on the cycle h_cnt = 0 and v_cnt = 0. Earlier requests in the same frame are overwritten (last wins).
- Patterns (px, py = active coordinates; ones = all-ones):
  - 0 black; 1 white; 2 red; 3 green; 4 blue.
  - 5 fine checker: px[4]^py[4], 0 or ones.
  - 6 coarse checker: px[6]^py[6].
  - 7 grey h-ramp: px[COLOR_W-1:0] on all channels.
  - 8 grey v-ramp: py[COLOR_W:1].
  - 9/10/11 red/green/blue h-ramp, other channels 0.
  - 12 colour bars, 8 bars of width H_ACTIVE/8, order: red, green, blue, magenta, yellow, cyan, white, black. The last bar absorbs the remainder.
  - 13 1-pixel white border on black.
  - other values white.

Optional Feature:
MOVING_BAR_EN
- Defined: adds mode 14. A vertical white bar 16 px wide on black. Its left edge bar_pos advances 1 px per frame_start and wraps to 0 when bar_pos+16 > H_ACTIVE. bar_pos resets to 0. Key wrap becomes 14->0.
- Undefined: mode 14 shows white; no bar_pos register; key wrap 13->0.

Decomposition:
- Package lcd_pkg: mode encoding constants (MODE_BLACK..MODE_MOVING_BAR), bar colour table, clog2 function.
- One sub-module: lcd_key_debounce (synchroniser, counter, single-pulse output). Reusable by other board demos.

Test Plan:
- Small params (H 8/2/1/1, V 4/1/1/1, sync low), reset release -> hsync low for h_cnt 0..1, de high h_cnt 3..10 of lines 2..5, period 12 clocks x 7 lines; frame_start every 84 clocks.
- mode_load 12 mid-frame, H_ACTIVE=16 -> pins unchanged until next frame_start. Then px 0..1 show FF0000, px 14..15 show 000000, rgb 0 outside de.
- key pressed 3 clocks with DEBOUNCE_CYCLES=4 -> no advance. Held 100 clocks -> exactly one advance, mode_out 0->1 at next frame.
- mode_load and key advance same cycle with mode_in=7 -> mode_out 7 next frame. Pending 13 plus key -> 0.
- rst_n asserted mid-line -> all outputs at reset values immediately, before any clock edge. After release, first frame_start occurs 1 clock later.
- MOVING_BAR_EN, mode 14, H_ACTIVE=32 -> bar at px 0..15, then 1..16, ..., wraps to 0 after pos 16.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: mode encoding, colour-bar table and width helper shared by the LCD
// timing/pattern generator and its key debouncer.
package lcd_pkg;
    typedef enum logic [3:0] {
        MODE_BLACK, MODE_WHITE, MODE_RED, MODE_GREEN, MODE_BLUE,
        MODE_CHECK_FINE, MODE_CHECK_COARSE, MODE_GREY_HRAMP, MODE_GREY_VRAMP,
        MODE_RED_HRAMP, MODE_GREEN_HRAMP, MODE_BLUE_HRAMP, MODE_BARS,
        MODE_BORDER, MODE_MOVING_BAR
    } mode_e;
    // {r,g,b} per bar, bar 0 in the low bits: red, green, blue, magenta, yellow, cyan, white, black
    localparam logic [23:0] BAR_RGB = {3'b000, 3'b111, 3'b011, 3'b110, 3'b101, 3'b001, 3'b010, 3'b100};
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r < 1 ? 1 : r;
    endfunction
endpackage

// File: rtl/lcd_timing_pattern_gen_if.sv
// lcd_timing_pattern_gen_if: parallel RGB panel bus plus frame/pixel side-band.
interface lcd_timing_pattern_gen_if #(parameter int COLOR_W = 8, parameter int X_W = 9, parameter int Y_W = 9);
    logic lcd_hsync, lcd_vsync, lcd_de, frame_start;
    logic [COLOR_W-1:0] lcd_r, lcd_g, lcd_b;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    modport master(output lcd_hsync, lcd_vsync, lcd_de, frame_start, lcd_r, lcd_g, lcd_b, pix_x, pix_y);
    modport slave(input lcd_hsync, lcd_vsync, lcd_de, frame_start, lcd_r, lcd_g, lcd_b, pix_x, pix_y);
endinterface

// File: rtl/lcd_key_debounce.sv
// lcd_key_debounce: synchronises an asynchronous push-button and emits one pulse
// once it has been held for DEBOUNCE_CYCLES clocks; holding never repeats.
module lcd_key_debounce import lcd_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit KEY_ACTIVE_LOW = 1
) (
    input logic lcd_clk,
    input logic rst_n,
    input logic key,
    output logic key_evt
);
    localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic pressed;
    assign pressed = sync[1] ^ KEY_ACTIVE_LOW;
    // counter saturates at FULL so a held key cannot wrap into a second event
    always_ff @(posedge lcd_clk or negedge rst_n)
        if (!rst_n) begin
            sync <= {2{KEY_ACTIVE_LOW}};
            cnt <= '0;
            key_evt <= 1'b0;
        end else begin
            sync <= {sync[0], key};
            cnt <= !pressed ? '0 : cnt == FULL ? FULL : cnt + 1'b1;
            key_evt <= pressed && cnt == LAST;
        end
endmodule

// File: rtl/lcd_timing_pattern_gen.sv
// lcd_timing_pattern_gen: parametrised RGB panel timing with built-in test patterns.
// Define MOVING_BAR_EN to add mode 14, a 16 px white bar stepping once per frame.
module lcd_timing_pattern_gen import lcd_pkg::*; #(
    parameter int H_ACTIVE = 480,
    parameter int H_SYNC = 41,
    parameter int H_BP = 2,
    parameter int H_FP = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_SYNC = 10,
    parameter int V_BP = 2,
    parameter int V_FP = 2,
    parameter bit SYNC_ACTIVE_HIGH = 0,
    parameter int COLOR_W = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit KEY_ACTIVE_LOW = 1
) (
    input logic lcd_clk,
    input logic rst_n,
    input logic key,
    input logic mode_load,
    input logic [3:0] mode_in,
    output logic [3:0] mode_out,
    lcd_timing_pattern_gen_if.master lcd
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW = clog2(H_TOTAL);
    localparam int VW = clog2(V_TOTAL);
    localparam int XW = clog2(H_ACTIVE);
    localparam int YW = clog2(V_ACTIVE);
    localparam int BAR_W = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [3:0] pending;
    logic key_evt, h_last, v_last, top, act, border;
    logic [15:0] px, py, bar_idx;
    logic [2:0] bar_sel, bar_rgb;
    logic [COLOR_W-1:0] r, g, b;
    lcd_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)) u_key (
        .lcd_clk(lcd_clk), .rst_n(rst_n), .key(key), .key_evt(key_evt)
    );
    assign h_last = int'(h_cnt) == H_TOTAL - 1;
    assign v_last = int'(v_cnt) == V_TOTAL - 1;
    assign top = h_cnt == '0 && v_cnt == '0;
    assign act = int'(h_cnt) >= H_SYNC + H_BP && int'(h_cnt) < H_SYNC + H_BP + H_ACTIVE
              && int'(v_cnt) >= V_SYNC + V_BP && int'(v_cnt) < V_SYNC + V_BP + V_ACTIVE;
    // widened coordinates so fixed bit picks stay legal for small panels
    assign px = 16'(int'(h_cnt) - (H_SYNC + H_BP));
    assign py = 16'(int'(v_cnt) - (V_SYNC + V_BP));
    assign bar_idx = px / 16'(BAR_W);
    assign bar_sel = bar_idx > 16'd7 ? 3'd7 : bar_idx[2:0];
    assign bar_rgb = BAR_RGB[3*bar_sel +: 3];
    assign border = px == '0 || px == 16'(H_ACTIVE - 1) || py == '0 || py == 16'(V_ACTIVE - 1);
`ifdef MOVING_BAR_EN
    localparam logic [3:0] MODE_LAST = MODE_MOVING_BAR;
    logic [XW-1:0] bar_pos;
    logic on_bar;
    assign on_bar = px >= 16'(bar_pos) && px < 16'(bar_pos) + 16'd16;
    always_ff @(posedge lcd_clk or negedge rst_n)
        if (!rst_n) bar_pos <= '0;
        else if (top) bar_pos <= int'(bar_pos) + 17 > H_ACTIVE ? '0 : bar_pos + 1'b1;
`else
    localparam logic [3:0] MODE_LAST = MODE_BORDER;
`endif
    always_comb begin
        {r, g, b} = '1;
        case (mode_out)
            MODE_BLACK: {r, g, b} = '0;
            MODE_RED: {g, b} = '0;
            MODE_GREEN: {r, b} = '0;
            MODE_BLUE: {r, g} = '0;
            MODE_CHECK_FINE: {r, g, b} = {3*COLOR_W{px[4] ^ py[4]}};
            MODE_CHECK_COARSE: {r, g, b} = {3*COLOR_W{px[6] ^ py[6]}};
            MODE_GREY_HRAMP: {r, g, b} = {3{px[COLOR_W-1:0]}};
            MODE_GREY_VRAMP: {r, g, b} = {3{py[COLOR_W:1]}};
            MODE_RED_HRAMP: {r, g, b} = {px[COLOR_W-1:0], {2*COLOR_W{1'b0}}};
            MODE_GREEN_HRAMP: {r, g, b} = {{COLOR_W{1'b0}}, px[COLOR_W-1:0], {COLOR_W{1'b0}}};
            MODE_BLUE_HRAMP: {r, g, b} = {{2*COLOR_W{1'b0}}, px[COLOR_W-1:0]};
            MODE_BARS: {r, g, b} = {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}};
            MODE_BORDER: {r, g, b} = {3*COLOR_W{border}};
`ifdef MOVING_BAR_EN
            MODE_MOVING_BAR: {r, g, b} = {3*COLOR_W{on_bar}};
`endif
            default: ;
        endcase
    end
    // mode_out only swaps on the first counter state of a frame to avoid tearing
    always_ff @(posedge lcd_clk or negedge rst_n)
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
            pending <= '0;
            mode_out <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            pending <= mode_load ? mode_in : key_evt ? (pending >= MODE_LAST ? '0 : pending + 1'b1) : pending;
            if (top) mode_out <= pending;
        end
    always_ff @(posedge lcd_clk or negedge rst_n)
        if (!rst_n) begin
            lcd.lcd_hsync <= !SYNC_ACTIVE_HIGH;
            lcd.lcd_vsync <= !SYNC_ACTIVE_HIGH;
            lcd.lcd_de <= 1'b0;
            lcd.frame_start <= 1'b0;
            lcd.lcd_r <= '0;
            lcd.lcd_g <= '0;
            lcd.lcd_b <= '0;
            lcd.pix_x <= '0;
            lcd.pix_y <= '0;
        end else begin
            lcd.lcd_hsync <= (int'(h_cnt) < H_SYNC) ~^ SYNC_ACTIVE_HIGH;
            lcd.lcd_vsync <= (int'(v_cnt) < V_SYNC) ~^ SYNC_ACTIVE_HIGH;
            lcd.lcd_de <= act;
            lcd.frame_start <= top;
            lcd.lcd_r <= act ? r : '0;
            lcd.lcd_g <= act ? g : '0;
            lcd.lcd_b <= act ? b : '0;
            lcd.pix_x <= act ? px[XW-1:0] : '0;
            lcd.pix_y <= act ? py[YW-1:0] : '0;
        end
endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// tb_lcd_timing_pattern_gen: small-panel bench with a frame-position model checked every cycle
// plus literal expectations for timing totals, key debounce and mode switching.
module tb_lcd_timing_pattern_gen;
    localparam int HA = 32, HS = 2, HB = 1, HF = 1, VA = 4, VS = 1, VB = 1, VF = 1, DEB = 4;
    localparam int HT = HA + HS + HB + HF, VT = VA + VS + VB + VF, FT = HT * VT;
`ifdef MOVING_BAR_EN
    localparam int LASTM = 14;
`else
    localparam int LASTM = 13;
`endif
    localparam logic [23:0] BARS [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF00FF,
                                         24'hFFFF00, 24'h00FFFF, 24'hFFFFFF, 24'h000000};
    logic lcd_clk = 0, rst_n = 1, key = 1, mode_load = 0;
    logic [3:0] mode_in = 0, mode_out;
    int tests = 0, fails = 0;
    int n, shown, pend, mode, rl, bpos, h, v, nrl, npend;
    bit evt, nevt, ks1, ks2, ede;
    lcd_timing_pattern_gen_if #(.COLOR_W(8), .X_W(5), .Y_W(2)) lcd();
    lcd_timing_pattern_gen #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_FP(HF), .V_ACTIVE(VA), .V_SYNC(VS),
        .V_BP(VB), .V_FP(VF), .SYNC_ACTIVE_HIGH(0), .COLOR_W(8), .DEBOUNCE_CYCLES(DEB), .KEY_ACTIVE_LOW(1)) dut (
        .lcd_clk(lcd_clk), .rst_n(rst_n), .key(key), .mode_load(mode_load), .mode_in(mode_in),
        .mode_out(mode_out), .lcd(lcd.master));
    always #5 lcd_clk = ~lcd_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pat(input int m, input int x, input int y, input int bp);
        int c;
        case (m)
            0: return 24'h0;
            2: return 24'hFF0000;
            3: return 24'h00FF00;
            4: return 24'h0000FF;
            5: return ((x / 16 + y / 16) % 2) ? 24'hFFFFFF : 24'h0;
            6: return ((x / 64 + y / 64) % 2) ? 24'hFFFFFF : 24'h0;
            7: begin c = x % 256; return {c[7:0], c[7:0], c[7:0]}; end
            8: begin c = (y / 2) % 256; return {c[7:0], c[7:0], c[7:0]}; end
            9: begin c = x % 256; return {c[7:0], 16'h0}; end
            10: begin c = x % 256; return {8'h0, c[7:0], 8'h0}; end
            11: begin c = x % 256; return {16'h0, c[7:0]}; end
            12: begin c = x / (HA / 8); return BARS[c > 7 ? 7 : c]; end
            13: return (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? 24'hFFFFFF : 24'h0;
`ifdef MOVING_BAR_EN
            14: return (x >= bp && x < bp + 16) ? 24'hFFFFFF : 24'h0;
`endif
            default: return 24'hFFFFFF;
        endcase
    endfunction

    // model: frame position of the values now on the pins, plus key/mode bookkeeping
    always @(posedge lcd_clk or negedge rst_n)
        if (!rst_n) begin
            n = 0; pend = 0; mode = 0; rl = 0; evt = 0; ks1 = 1; ks2 = 1; bpos = 0; shown = 0;
        end else begin
            nrl = !ks2 ? (rl < DEB ? rl + 1 : DEB) : 0;
            nevt = !ks2 && rl + 1 == DEB;
            npend = mode_load ? int'(mode_in) : evt ? (pend >= LASTM ? 0 : pend + 1) : pend;
            shown = n % FT;
            if (shown == 0) begin
                mode = pend;
                bpos = bpos + 17 > HA ? 0 : bpos + 1;
            end
            pend = npend; evt = nevt; rl = nrl; ks2 = ks1; ks1 = key;
            n++;
        end

    always @(negedge lcd_clk)
        if (rst_n && n > 0) begin
            h = shown % HT;
            v = shown / HT;
            ede = h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
            check("hsync", lcd.lcd_hsync, h >= HS);
            check("vsync", lcd.lcd_vsync, v >= VS);
            check("de", lcd.lcd_de, ede);
            check("frame_start", lcd.frame_start, shown == 0);
            check("mode_out", mode_out, mode);
            if (ede) begin
                check("pix_x", lcd.pix_x, h - HS - HB);
                check("pix_y", lcd.pix_y, v - VS - VB);
                check("rgb", {lcd.lcd_r, lcd.lcd_g, lcd.lcd_b}, pat(mode, h - HS - HB, v - VS - VB, bpos));
            end else check("rgb_blank", {lcd.lcd_r, lcd.lcd_g, lcd.lcd_b}, 0);
        end

    task automatic cycles(input int k);
        repeat (k) @(negedge lcd_clk);
    endtask

    task automatic wait_px(input int x, input int y);
        int t = 0;
        while (!(lcd.lcd_de && lcd.pix_x == 5'(x) && lcd.pix_y == 2'(y)) && t < 2 * FT) begin
            @(posedge lcd_clk); #1; t++;
        end
        check("wait_px_timeout", t < 2 * FT, 1);
    endtask

    task automatic load(input int m);
        @(negedge lcd_clk); mode_load = 1; mode_in = 4'(m);
        @(negedge lcd_clk); mode_load = 0;
    endtask

    task automatic press(input int k);
        @(negedge lcd_clk); key = 0;
        cycles(k);
        key = 1;
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_hsync"}, lcd.lcd_hsync, 1);
        check({tag, "_vsync"}, lcd.lcd_vsync, 1);
        check({tag, "_de"}, lcd.lcd_de, 0);
        check({tag, "_fs"}, lcd.frame_start, 0);
        check({tag, "_rgb"}, {lcd.lcd_r, lcd.lcd_g, lcd.lcd_b}, 0);
        check({tag, "_pix"}, {lcd.pix_x, lcd.pix_y}, 0);
        check({tag, "_mode"}, mode_out, 0);
    endtask

    initial begin
        int cyc, dec, hl, vl;
        #1 rst_n = 0;
        #1 check_reset_pins("reset");
        cycles(3);
        rst_n = 1;
        @(posedge lcd_clk); #1;
        check("first_fs", lcd.frame_start, 1);
        check("first_hsync_low", lcd.lcd_hsync, 0);
        check("first_vsync_low", lcd.lcd_vsync, 0);
        cyc = 0; dec = 0; hl = 0; vl = 0;
        do begin
            cyc++; dec += int'(lcd.lcd_de); hl += int'(!lcd.lcd_hsync); vl += int'(!lcd.lcd_vsync);
            @(posedge lcd_clk); #1;
        end while (!lcd.frame_start && cyc < 1000);
        check("frame_period", cyc, 252);
        check("de_per_frame", dec, 128);
        check("hsync_low_per_frame", hl, 14);
        check("vsync_low_per_frame", vl, 36);
        // mode change requested mid-frame must wait for the next frame
        wait_px(5, 1);
        @(negedge lcd_clk);
        load(12);
        check("load_deferred", mode_out, 0);
        wait_px(0, 0);
        check("bar_red", {lcd.lcd_r, lcd.lcd_g, lcd.lcd_b}, 24'hFF0000);
        wait_px(4, 0);
        check("bar_green", {lcd.lcd_r, lcd.lcd_g, lcd.lcd_b}, 24'h00FF00);
        wait_px(31, 0);
        check("bar_black", {lcd.lcd_r, lcd.lcd_g, lcd.lcd_b}, 24'h000000);
        load(0);
        cycles(2 * FT);
        press(3);
        cycles(2 * FT);
        check("short_press_ignored", mode_out, 0);
        press(100);
        cycles(2 * FT);
        check("long_press_single_advance", mode_out, 1);
        // key event lands on the same cycle as mode_load: load wins
        @(negedge lcd_clk); key = 0;
        cycles(6);
        mode_load = 1; mode_in = 7;
        @(negedge lcd_clk); mode_load = 0;
        cycles(20); key = 1;
        cycles(2 * FT);
        check("load_beats_key", mode_out, 7);
        load(LASTM);
        cycles(2 * FT);
        check("last_mode", mode_out, LASTM);
        press(20);
        cycles(2 * FT);
        check("key_wrap", mode_out, 0);
        for (int m = 0; m < 16; m++) begin
            load(m);
            cycles(2 * FT);
        end
        load(1);
        cycles(2 * FT);
        wait_px(10, 2);
        check("white_before_reset", {lcd.lcd_r, lcd.lcd_g, lcd.lcd_b}, 24'hFFFFFF);
        #1 rst_n = 0;
        #1 check_reset_pins("midline_reset");
        cycles(3);
        rst_n = 1;
        @(posedge lcd_clk); #1;
        check("fs_after_reset", lcd.frame_start, 1);
        cycles(2 * FT);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
